// File: rtl/defines_pkg.sv
`default_nettype none
// ============================================================================
// Module      : defines_pkg
// Description : Shared types and widths for the data-memory responder path.
// Revision    : 1.0 - initial release
// ============================================================================
package defines_pkg;

    localparam int DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Synchronous single-port word storage; read-during-write
//               returns the newly written data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import defines_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic                   i_re,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [DMEM_DATA_W-1:0] i_wdata,
    output logic [DMEM_DATA_W-1:0] o_rdata
);

    logic [DMEM_DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DMEM_DATA_W-1:0] r_rdata;

    // Storage itself is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_we) begin
            r_rdata <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency load/store responder for the mem stage.
//               Optional macro DMEM_ALIGN_CHECK_EN flags odd addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import defines_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_memdm_p1,
    output logic                   req_ready_dmmem_p1,
    input  logic                   req_write_memdm_p1,
    input  logic [15:0]            req_addr_memdm_p1,
    input  logic [DMEM_DATA_W-1:0] req_wdata_memdm_p1,
    output logic                   resp_valid_dmmem_p1,
    output logic [DMEM_DATA_W-1:0] resp_rdata_dmmem_p1,
    output logic                   resp_err_dmmem_p1
);

    localparam int c_addr_w = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w  = ($clog2(LATENCY) < 1) ? 1 : $clog2(LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_load =
        (LATENCY >= 2) ? c_cnt_w'(LATENCY - 2) : '0;

    dmem_state_t            r_state;
    dmem_state_t            w_state_next;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_next;
    logic                   r_write;
    logic                   r_err;

    logic [14:0]            w_word_idx;
    logic                   w_oob;
    logic                   w_misalign;
    logic                   w_err;
    logic                   w_accept;
    logic                   w_store_en;
    logic                   w_load_en;
    logic [DMEM_DATA_W-1:0] w_array_rdata;

    assign w_word_idx = req_addr_memdm_p1[15:1];
    assign w_oob      = ({1'b0, w_word_idx} >= 16'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = req_addr_memdm_p1[0];
`else
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = req_addr_memdm_p1[0];
    assign w_misalign        = 1'b0;
`endif

    assign w_err      = w_oob | w_misalign;
    assign w_accept   = req_valid_memdm_p1 & req_ready_dmmem_p1;
    assign w_store_en = w_accept &  req_write_memdm_p1 & ~w_err;
    assign w_load_en  = w_accept & ~req_write_memdm_p1 & ~w_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_addr_w)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_store_en),
        .i_re    (w_load_en),
        .i_addr  (req_addr_memdm_p1[c_addr_w:1]),
        .i_wdata (req_wdata_memdm_p1),
        .o_rdata (w_array_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write <= req_write_memdm_p1;
                r_err   <= w_err;
            end
        end
    end

    // RESP doubles as an accept slot so back-to-back requests lose no cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_cnt_load;
                    end
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign req_ready_dmmem_p1  = rst & (r_state != WAIT);
    assign resp_valid_dmmem_p1 = (r_state == RESP);
    assign resp_err_dmmem_p1   = resp_valid_dmmem_p1 & r_err;
    assign resp_rdata_dmmem_p1 = (resp_valid_dmmem_p1 & ~r_write & ~r_err)
                                 ? w_array_rdata : '0;

endmodule
`default_nettype wire
